// File: rtl/model_writer.sv
// Streams one model's vertices and faces into RAM write ports, bracketed by header writes.
// Optional MODEL_WRITER_BOUNDS_CHECK_EN: saturating pointers with full/error detection.
module model_writer #(
  parameter int MODEL_INDEX_WIDTH = 4,
  parameter int INDEX_ADDR_WIDTH  = 15,
  parameter int VERTEX_ADDR_WIDTH = 15,
  parameter int COORDINATE_WIDTH  = 24
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          start,
  input  logic [MODEL_INDEX_WIDTH-1:0]                  model_index,
  input  logic signed [2:0][COORDINATE_WIDTH-1:0]       vertex_data,
  input  logic                                          vertex_i_dv,
  input  logic                                          vertex_data_last,
  input  logic [2:0][INDEX_ADDR_WIDTH-1:0]              index_data,
  input  logic                                          index_i_dv,
  input  logic                                          index_data_last,
  output logic                                          vertex_ready,
  output logic                                          index_ready,
  output logic                                          busy,
  output logic                                          done,
  output logic                                          error,
  output logic                                          header_we,
  output logic [MODEL_INDEX_WIDTH-1:0]                  header_addr,
  output logic [INDEX_ADDR_WIDTH+VERTEX_ADDR_WIDTH-1:0] header_wdata,
  output logic                                          face_we,
  output logic [INDEX_ADDR_WIDTH-1:0]                   face_addr,
  output logic [3*INDEX_ADDR_WIDTH-1:0]                 face_wdata,
  output logic                                          vertex_we,
  output logic [VERTEX_ADDR_WIDTH-1:0]                  vertex_addr,
  output logic [3*COORDINATE_WIDTH-1:0]                 vertex_wdata
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] HDR_START = 3'd1;
  localparam logic [2:0] LOAD      = 3'd2;
  localparam logic [2:0] HDR_END   = 3'd3;
  localparam logic [2:0] DONE      = 3'd4;

  logic [2:0]                   state;
  logic [MODEL_INDEX_WIDTH-1:0] idx;
  logic [INDEX_ADDR_WIDTH-1:0]  face_ptr;
  logic [VERTEX_ADDR_WIDTH-1:0] vertex_ptr;
  logic                         v_closed, f_closed;
  logic                         v_acc, f_acc;
`ifdef MODEL_WRITER_BOUNDS_CHECK_EN
  logic                         v_full, f_full;
`endif

  // Ready is derived from registered state only, so it never depends on dv.
  assign vertex_ready = (state == LOAD) && !v_closed;
  assign index_ready  = (state == LOAD) && !f_closed;
  assign busy         = (state != IDLE);
  assign v_acc        = vertex_i_dv && vertex_ready;
  assign f_acc        = index_i_dv && index_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      face_ptr     <= '0;
      vertex_ptr   <= '0;
      v_closed     <= 1'b0;
      f_closed     <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      header_we    <= 1'b0;
      header_addr  <= '0;
      header_wdata <= '0;
      face_we      <= 1'b0;
      face_addr    <= '0;
      face_wdata   <= '0;
      vertex_we    <= 1'b0;
      vertex_addr  <= '0;
      vertex_wdata <= '0;
`ifdef MODEL_WRITER_BOUNDS_CHECK_EN
      v_full       <= 1'b0;
      f_full       <= 1'b0;
`endif
    end else begin
      header_we <= 1'b0;
      face_we   <= 1'b0;
      vertex_we <= 1'b0;
      done      <= 1'b0;

      if (v_acc) begin
`ifdef MODEL_WRITER_BOUNDS_CHECK_EN
        if (v_full) begin
          error <= 1'b1;
        end else begin
          vertex_we    <= 1'b1;
          vertex_addr  <= vertex_ptr;
          vertex_wdata <= vertex_data;
          if (&vertex_ptr) v_full <= 1'b1;
          else             vertex_ptr <= vertex_ptr + 1'b1;
        end
`else
        vertex_we    <= 1'b1;
        vertex_addr  <= vertex_ptr;
        vertex_wdata <= vertex_data;
        vertex_ptr   <= vertex_ptr + 1'b1;
`endif
        if (vertex_data_last) v_closed <= 1'b1;
      end

      if (f_acc) begin
`ifdef MODEL_WRITER_BOUNDS_CHECK_EN
        if (f_full) begin
          error <= 1'b1;
        end else begin
          face_we    <= 1'b1;
          face_addr  <= face_ptr;
          face_wdata <= index_data;
          if (&face_ptr) f_full <= 1'b1;
          else           face_ptr <= face_ptr + 1'b1;
        end
`else
        face_we    <= 1'b1;
        face_addr  <= face_ptr;
        face_wdata <= index_data;
        face_ptr   <= face_ptr + 1'b1;
`endif
        if (index_data_last) f_closed <= 1'b1;
      end

      // Header writes are registered on the entering edge so they land in the state's cycle.
      case (state)
        IDLE: if (start) begin
          idx          <= model_index;
          error        <= 1'b0;
          v_closed     <= 1'b0;
          f_closed     <= 1'b0;
          header_we    <= 1'b1;
          header_addr  <= model_index;
          header_wdata <= {face_ptr, vertex_ptr};
          state        <= HDR_START;
        end
        HDR_START: state <= LOAD;
        LOAD: if (v_closed && f_closed) begin
          header_we    <= 1'b1;
          header_addr  <= idx + 1'b1;
          header_wdata <= {face_ptr, vertex_ptr};
          state        <= HDR_END;
        end
        HDR_END: begin
          done  <= 1'b1;
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
